ins_fetcher: RTL and testbench
==============================

// Module: ins_fetcher
// PURPOSE
//   Instruction fetch stage upstream of the decoder. Holds the fetch PC and a direct-mapped one-word-per-line icache.
//   Also holds a 2-bit-counter branch history table (BHT) for B-type prediction.
//   Presents {ins, pc, pred_jump} to the decoder and obeys its stall/redirect, plus ROB mispredict flushes.
// PARAMETERS
//   ICACHE_IDX_BITS  4    icache lines = 2**ICACHE_IDX_BITS, index = pc[ICACHE_IDX_BITS+1:2], tag = remaining upper pc bits
//   BHT_IDX_BITS     6    BHT entries = 2**BHT_IDX_BITS, index = pc[BHT_IDX_BITS+1:2]
//   RESET_PC         0    first fetch address
// PORTS
//   clk_in        in   1   clock
//   rst_in        in   1   reset, asynchronous, active-high
//   rdy_in        in   1   when low, all state frozen
//   ins_ready     out  1   {ins,pc,pred_jump} valid
//   ins           out  32  instruction word
//   pc            out  32  address of ins
//   pred_jump     out  1   1 = B-type predicted taken
//   dec_stall     in   1   decoder cannot accept the presented instruction this cycle
//   dec_clear     in   1   decoder redirect (JAL/JALR/branch)
//   dec_new_addr  in   32  redirect target for dec_clear
//   rob_clear     in   1   mispredict flush
//   rob_new_pc    in   32  correct PC on flush
//   br_valid      in   1   BHT update strobe from commit
//   br_pc         in   32  committed branch PC
//   br_taken      in   1   committed branch outcome
//   mem_req       out  1   word fetch request to memory controller
//   mem_addr      out  32  word-aligned fetch address
//   mem_done      in   1   one-cycle pulse: mem_data valid
//   mem_data      in   32  fetched word
// BEHAVIOUR
//  - Reset: ins_ready=0, ins=0, pc=0, pred_jump=0, mem_req=0, mem_addr=0, fetch_pc=RESET_PC, state=IDLE.
//    All icache valid bits cleared; all BHT counters set to 2'b01 (weakly not-taken).
//  - Event priority per rdy_in cycle: rob_clear > dec_clear > dec_stall > normal fetch.
//  - States: IDLE (lookup) and MISS (waiting on memory).
//  - IDLE, hit (valid & tag match on fetch_pc), not stalled:
//    - Next edge: ins_ready=1, ins=line, pc=fetch_pc.
//    - pred_jump = (opcode==7'b1100011) & bht[1].
//    - fetch_pc <= pred_jump ? fetch_pc+sext(immB) : fetch_pc+4. 32-bit wrap, no overflow check.
//    - JAL/JALR advance by +4; the decoder's dec_clear performs the redirect.
//  - IDLE, miss, not stalled: ins_ready<=0, mem_req<=1, mem_addr<=fetch_pc, state<=MISS.
//  - MISS:
//    - mem_req and mem_addr are held until mem_done.
//    - On mem_done: write line (valid=1, tag) at mem_addr's index; mem_req<=0; state<=IDLE.
//    - The next IDLE cycle hits, so miss latency = memory latency + 1 cycle.
//  - dec_stall=1 with ins_ready=1: ins/pc/pred_jump/ins_ready held, fetch_pc unchanged. A MISS in progress keeps waiting.
//  - dec_clear or rob_clear: fetch_pc<=new target; ins_ready<=0 on the next edge.
//    - If in MISS, the outstanding request is not cancelled. The fill completes into the cache (data valid for mem_addr).
//    - Fetching then resumes from the new fetch_pc.
//    - A clear arriving the same cycle as mem_done does both.
//  - BHT update on br_valid: saturating counter at br_pc index, +1 if taken, -1 if not, saturating at 0 and 3.
//    A same-cycle lookup of that entry sees the old value.
//  - rdy_in=0: no register changes. Outputs hold. mem_done arriving while rdy_in=0 is the controller's responsibility not to issue.
//  - The icache is never invalidated except by reset; self-modifying code is unsupported.
// TESTING
//  - Reset, memory returns 0x00500093 @0 after 3 cycles -> mem_req@0 held 3 cycles; ins_ready=1, ins=0x00500093, pc=0 two cycles after mem_done.
//  - Straight line 0,4,8 all cached -> ins_ready high on consecutive cycles, pc=0,4,8.
//  - dec_stall held 2 cycles while pc=4 presented -> pc=4 and ins held; pc=8 on the cycle after the stall drops.
//  - beq at 0x10 with imm=-8, BHT counter 2'b11 -> pred_jump=1, next pc=0x08.
//    - Repeat with the counter at 2'b01 -> pred_jump=0, next pc=0x14.
//  - dec_clear to 0x100 during MISS @0x20:
//    - mem_req stays on 0x20 until done, and line 0x20 is filled.
//    - The next request is 0x100; no instruction from 0x20 is presented.
//  - rob_clear and dec_clear in the same cycle -> fetch_pc=rob_new_pc.
//    - br_valid taken x3 on an entry at 01 -> saturates at 11.

Source files
------------

// File: rtl/ins_fetcher.sv
// Instruction fetch stage: fetch PC, direct-mapped one-word-per-line icache and a
// 2-bit saturating branch history table, presenting {ins, pc, pred_jump} to the decoder.
module ins_fetcher #(
    parameter int unsigned ICACHE_IDX_BITS = 4,
    parameter int unsigned BHT_IDX_BITS    = 6,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        ins_ready,
    output logic [31:0] ins,
    output logic [31:0] pc,
    output logic        pred_jump,
    input  logic        dec_stall,
    input  logic        dec_clear,
    input  logic [31:0] dec_new_addr,
    input  logic        rob_clear,
    input  logic [31:0] rob_new_pc,
    input  logic        br_valid,
    input  logic [31:0] br_pc,
    input  logic        br_taken,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_done,
    input  logic [31:0] mem_data
);
    localparam int unsigned LINES    = 1 << ICACHE_IDX_BITS;
    localparam int unsigned TAG_BITS = 32 - ICACHE_IDX_BITS - 2;
    localparam int unsigned BHT_SIZE = 1 << BHT_IDX_BITS;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MISS = 1'b1
    } state_t;

    state_t                     state_r;
    logic [31:0]                fetch_pc_r;
    logic [LINES-1:0]           valid_r;
    logic [TAG_BITS-1:0]        tag_r  [LINES];
    logic [31:0]                data_r [LINES];
    logic [1:0]                 bht_r  [BHT_SIZE];

    logic [ICACHE_IDX_BITS-1:0] lookup_idx_s;
    logic [ICACHE_IDX_BITS-1:0] fill_idx_s;
    logic [TAG_BITS-1:0]        lookup_tag_s;
    logic [TAG_BITS-1:0]        fill_tag_s;
    logic [BHT_IDX_BITS-1:0]    bht_rd_idx_s;
    logic [BHT_IDX_BITS-1:0]    bht_wr_idx_s;
    logic [31:0]                line_s;
    logic                       hit_s;
    logic                       pred_s;
    logic [31:0]                next_pc_s;
    logic                       fill_s;
    logic                       unused_br_pc_s;

    function automatic logic [31:0] imm_b(input logic [31:0] w);
        imm_b = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
    endfunction

    function automatic logic [1:0] sat_step(input logic [1:0] c, input logic taken);
        logic [1:0] r;
        if (taken) begin
            if (c != 2'b11) r = c + 2'b01;
            else            r = c;
        end else begin
            if (c != 2'b00) r = c - 2'b01;
            else            r = c;
        end
        return r;
    endfunction

    assign unused_br_pc_s = ^{br_pc[31:BHT_IDX_BITS+2], br_pc[1:0]};

    // Cache/BHT lookup on the current fetch PC and fill-slot decode from the pending request.
    always_comb begin
        lookup_idx_s = fetch_pc_r[ICACHE_IDX_BITS+1:2];
        lookup_tag_s = fetch_pc_r[31:ICACHE_IDX_BITS+2];
        fill_idx_s   = mem_addr[ICACHE_IDX_BITS+1:2];
        fill_tag_s   = mem_addr[31:ICACHE_IDX_BITS+2];
        bht_rd_idx_s = fetch_pc_r[BHT_IDX_BITS+1:2];
        bht_wr_idx_s = br_pc[BHT_IDX_BITS+1:2];
        line_s       = data_r[lookup_idx_s];
        hit_s        = valid_r[lookup_idx_s] && (tag_r[lookup_idx_s] == lookup_tag_s);
        pred_s       = (line_s[6:0] == OPC_BRANCH) && bht_r[bht_rd_idx_s][1];
        fill_s       = (state_r == S_MISS) && mem_done;
        if (pred_s) begin
            next_pc_s = fetch_pc_r + imm_b(line_s);
        end else begin
            next_pc_s = fetch_pc_r + 32'd4;
        end
    end

    // Line payload storage; only the valid bits need a reset value.
    always_ff @(posedge clk_in) begin
        if (rdy_in && fill_s) begin
            tag_r[fill_idx_s]  <= fill_tag_s;
            data_r[fill_idx_s] <= mem_data;
        end
    end

    // Valid bits and branch history counters.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_r <= {LINES{1'b0}};
            for (int i = 0; i < BHT_SIZE; i++) begin
                bht_r[i] <= 2'b01;
            end
        end else if (rdy_in) begin
            if (fill_s) begin
                valid_r[fill_idx_s] <= 1'b1;
            end
            if (br_valid) begin
                bht_r[bht_wr_idx_s] <= sat_step(bht_r[bht_wr_idx_s], br_taken);
            end
        end
    end

    // Fetch FSM and registered decoder/memory outputs.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r    <= S_IDLE;
            fetch_pc_r <= RESET_PC;
            ins_ready  <= 1'b0;
            ins        <= 32'h0000_0000;
            pc         <= 32'h0000_0000;
            pred_jump  <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= 32'h0000_0000;
        end else if (rdy_in) begin
            // A fill always completes, even when a redirect lands in the same cycle.
            if (fill_s) begin
                mem_req <= 1'b0;
                state_r <= S_IDLE;
            end
            if (rob_clear) begin
                fetch_pc_r <= rob_new_pc;
                ins_ready  <= 1'b0;
            end else if (dec_clear) begin
                fetch_pc_r <= dec_new_addr;
                ins_ready  <= 1'b0;
            end else if (dec_stall) begin
                fetch_pc_r <= fetch_pc_r;
            end else if (state_r == S_IDLE) begin
                if (hit_s) begin
                    ins_ready  <= 1'b1;
                    ins        <= line_s;
                    pc         <= fetch_pc_r;
                    pred_jump  <= pred_s;
                    fetch_pc_r <= next_pc_s;
                end else begin
                    ins_ready <= 1'b0;
                    mem_req   <= 1'b1;
                    mem_addr  <= {fetch_pc_r[31:2], 2'b00};
                    state_r   <= S_MISS;
                end
            end else begin
                fetch_pc_r <= fetch_pc_r;
            end
        end
    end
endmodule

// File: tb/tb_ins_fetcher.sv
// Bench for ins_fetcher: memory responder, presentation scoreboard, branch-prediction
// vector table and hand sequences for miss, stall, freeze and redirect corners.
module tb_ins_fetcher;
    logic        clk_in, rst_in, rdy_in;
    logic        ins_ready, pred_jump;
    logic [31:0] ins, pc;
    logic        dec_stall, dec_clear, rob_clear, br_valid, br_taken;
    logic [31:0] dec_new_addr, rob_new_pc, br_pc;
    logic        mem_req, mem_done;
    logic [31:0] mem_addr, mem_data;

    ins_fetcher #(.ICACHE_IDX_BITS(4), .BHT_IDX_BITS(6), .RESET_PC(32'h0000_0000)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .ins_ready(ins_ready), .ins(ins), .pc(pc), .pred_jump(pred_jump),
        .dec_stall(dec_stall), .dec_clear(dec_clear), .dec_new_addr(dec_new_addr),
        .rob_clear(rob_clear), .rob_new_pc(rob_new_pc),
        .br_valid(br_valid), .br_pc(br_pc), .br_taken(br_taken),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_done(mem_done), .mem_data(mem_data)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        pj;
    } pres_t;

    typedef struct {
        logic [31:0] word;
        logic [7:0]  upd_bits;
        int          upd_n;
        logic        exp_pj;
        logic [31:0] exp_next;
    } vec_t;

    pres_t       exp_q[$];
    pres_t       last_exp;
    logic [31:0] req_log[$];
    logic [31:0] mem [0:255];
    logic [31:0] watch_addr;
    int          total, bad, cyc_cnt, done_cyc, last_pop_cyc, req_cnt, wait_cnt, n, clr_cyc;
    int          mem_lat;
    logic        prev_ready;
    vec_t        tab [7];

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        cyc_cnt = 0;
        forever begin
            @(posedge clk_in);
            cyc_cnt = cyc_cnt + 1;
        end
    end

    // memory controller model: done pulse on the mem_lat-th cycle of a request
    initial begin
        mem_done = 1'b0;
        mem_data = 32'h0;
        wait_cnt = 0;
        done_cyc = 0;
        forever begin
            @(negedge clk_in);
            mem_done = 1'b0;
            if (mem_req === 1'b1) begin
                wait_cnt = wait_cnt + 1;
                if (wait_cnt == mem_lat) begin
                    mem_done = 1'b1;
                    mem_data = mem[mem_addr[9:2]];
                    done_cyc = cyc_cnt;
                    req_log.push_back(mem_addr);
                    wait_cnt = 0;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total = total + 1;
        if (act !== req) begin
            bad = bad + 1;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [31:0] a, input logic pj);
        pres_t e;
        e.pc  = a;
        e.ins = mem[a[9:2]];
        e.pj  = pj;
        exp_q.push_back(e);
    endtask

    // one cycle: advance to negedge, score the presented instruction
    task automatic cyc();
        logic held;
        pres_t e;
        @(negedge clk_in);
        held = prev_ready && (!rdy_in || (dec_stall && !rob_clear && !dec_clear));
        if (ins_ready === 1'b1) begin
            if (held) begin
                chk("held_pc", pc, last_exp.pc);
                chk("held_ins", ins, last_exp.ins);
            end else if (exp_q.size() == 0) begin
                total = total + 1;
                bad = bad + 1;
                $display("FAIL unexpected: pc %h presented, none wanted", pc);
            end else begin
                e = exp_q.pop_front();
                last_exp = e;
                last_pop_cyc = cyc_cnt;
                chk("pres_pc", pc, e.pc);
                chk("pres_ins", ins, e.ins);
                chk("pres_pj", {31'd0, pred_jump}, {31'd0, e.pj});
            end
        end
        if (mem_req === 1'b1 && mem_addr == watch_addr) req_cnt = req_cnt + 1;
        prev_ready = ins_ready;
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        dec_stall = 1'b0;
        while (exp_q.size() != 0 && k < budget) begin
            cyc();
            k = k + 1;
        end
        dec_stall = 1'b1;
        total = total + 1;
        if (exp_q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL drain_timeout: %0d left want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic redirect(input logic use_rob, input logic [31:0] a);
        if (use_rob) begin
            rob_clear = 1'b1;
            rob_new_pc = a;
        end else begin
            dec_clear = 1'b1;
            dec_new_addr = a;
        end
        cyc();
        rob_clear = 1'b0;
        dec_clear = 1'b0;
    endtask

    task automatic reset_dut();
        rst_in = 1'b1;
        rdy_in = 1'b1;
        dec_stall = 1'b1;
        dec_clear = 1'b0;
        rob_clear = 1'b0;
        br_valid = 1'b0;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        prev_ready = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        total = 0; bad = 0; req_cnt = 0; last_pop_cyc = 0; mem_lat = 3;
        prev_ready = 1'b0; watch_addr = 32'h0;
        dec_new_addr = 32'h0; rob_new_pc = 32'h0; br_pc = 32'h0; br_taken = 1'b0;
        last_exp.pc = 32'h0; last_exp.ins = 32'h0; last_exp.pj = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;
        mem[0] = 32'h0050_0093;

        // branch-prediction vectors: branch word at 0x10, BHT updates applied first
        tab[0] = '{32'hFE00_0CE3, 8'b0000_0011, 2, 1'b1, 32'h0000_0008};
        tab[1] = '{32'hFE00_0CE3, 8'b0000_0000, 0, 1'b0, 32'h0000_0014};
        tab[2] = '{32'h0020_9863, 8'b0000_0001, 1, 1'b1, 32'h0000_0020};
        tab[3] = '{32'h0080_006F, 8'b0000_0011, 2, 1'b0, 32'h0000_0014};
        tab[4] = '{32'hFE00_0CE3, 8'b0000_0111, 5, 1'b0, 32'h0000_0014};
        tab[5] = '{32'hFE00_0CE3, 8'b0000_1100, 4, 1'b1, 32'h0000_0008};
        tab[6] = '{32'hFE00_0CE3, 8'b0000_0111, 3, 1'b1, 32'h0000_0008};

        // reset state and first cold miss
        reset_dut();
        chk("rst_ready", {31'd0, ins_ready}, 32'd0);
        chk("rst_ins", ins, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_pj", {31'd0, pred_jump}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        watch_addr = 32'h0; req_cnt = 0;
        push_exp(32'h0, 1'b0);
        drain(40);
        chk("first_req_cycles", 32'(req_cnt), 32'd3);
        chk("first_latency", 32'(last_pop_cyc - done_cyc), 32'd2);

        // warm 4 and 8, then replay 0,4,8 from cache back to back
        push_exp(32'h4, 1'b0);
        push_exp(32'h8, 1'b0);
        drain(40);
        clr_cyc = cyc_cnt;
        redirect(1'b1, 32'h0);
        push_exp(32'h0, 1'b0); push_exp(32'h4, 1'b0); push_exp(32'h8, 1'b0);
        drain(20);
        chk("straight_consec", 32'(last_pop_cyc - clr_cyc), 32'd4);

        // stall two cycles on pc=4, then 8 follows
        redirect(1'b1, 32'h0);
        push_exp(32'h0, 1'b0); push_exp(32'h4, 1'b0);
        drain(20);
        cyc(); chk("stall_pc1", pc, 32'h4);
        cyc(); chk("stall_pc2", pc, 32'h4);
        push_exp(32'h8, 1'b0);
        dec_stall = 1'b0;
        cyc();
        dec_stall = 1'b1;
        chk("after_stall_pc", pc, 32'h8);
        chk("after_stall_q", 32'(exp_q.size()), 32'd0);

        // rdy_in low freezes everything even with the decoder free
        dec_stall = 1'b0; rdy_in = 1'b0;
        cyc(); cyc();
        chk("freeze_pc", pc, 32'h8);
        rdy_in = 1'b1; dec_stall = 1'b1;

        // decoder redirect while a miss to 0x20 is outstanding
        req_log.delete(); watch_addr = 32'h20; req_cnt = 0;
        dec_stall = 1'b0;
        redirect(1'b1, 32'h20);
        n = 0;
        while (mem_req !== 1'b1 && n < 10) begin cyc(); n = n + 1; end
        chk("miss_seen", {31'd0, mem_req}, 32'd1);
        chk("miss_addr", mem_addr, 32'h20);
        redirect(1'b0, 32'h100);
        push_exp(32'h100, 1'b0);
        drain(40);
        chk("clr_miss_held", 32'(req_cnt), 32'd3);
        chk("clr_req_count", 32'(req_log.size()), 32'd2);
        if (req_log.size() == 2) begin
            chk("clr_req0", req_log[0], 32'h20);
            chk("clr_req1", req_log[1], 32'h100);
        end
        req_log.delete();
        redirect(1'b1, 32'h20);
        push_exp(32'h20, 1'b0);
        drain(20);
        chk("fill_kept_no_req", 32'(req_log.size()), 32'd0);

        // rob_clear wins over dec_clear
        req_log.delete();
        rob_clear = 1'b1; rob_new_pc = 32'h40;
        dec_clear = 1'b1; dec_new_addr = 32'h80;
        cyc();
        rob_clear = 1'b0; dec_clear = 1'b0;
        push_exp(32'h40, 1'b0);
        drain(40);
        chk("prio_req", (req_log.size() > 0) ? req_log[0] : 32'hDEAD_BEEF, 32'h40);

        // prediction table
        for (int i = 0; i < 7; i++) begin
            reset_dut();
            mem[4] = tab[i].word;
            for (int j = 0; j < tab[i].upd_n; j++) begin
                br_valid = 1'b1; br_pc = 32'h10; br_taken = tab[i].upd_bits[j];
                cyc();
            end
            br_valid = 1'b0;
            push_exp(32'h0, 1'b0); push_exp(32'h4, 1'b0);
            push_exp(32'h8, 1'b0); push_exp(32'hC, 1'b0);
            push_exp(32'h10, tab[i].exp_pj);
            push_exp(tab[i].exp_next, 1'b0);
            drain(200);
            chk("tab_next_pc", pc, tab[i].exp_next);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
